// File: rtl/wb_pkg.sv
// wb_pkg: write-back select codes, default widths and FIFO count-width helper
package wb_pkg;
   localparam int WB_SEL_IMM = 0;
   localparam int WB_SEL_ALU = 1;
   localparam int WB_SEL_MEM = 2;
   localparam int WB_DATA_W  = 16;
   localparam int WB_REG_AW  = 3;
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/outport_fifo.sv
// outport_fifo: synchronous power-of-two FIFO with occupancy count; storage is not reset
module outport_fifo
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [DATA_W-1:0]         wdata,
   output logic                      full,
   output logic                      empty,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic [DATA_W-1:0]         rdata
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   assign rdata = empty ? '0 : mem[rd_ptr];
   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/wb_outport_unit.sv
// wb_outport_unit: write-back source mux, register-file port and OUT FIFO with stall
// WB_SEL_CHECK_EN builds a sticky illegal-select flag on sel_err; otherwise sel_err is 0
module wb_outport_unit
   import wb_pkg::*;
#(
   parameter int DATA_W    = WB_DATA_W,
   parameter int NUM_SRC   = 3,
   parameter int SEL_W     = 2,
   parameter int REG_AW    = WB_REG_AW,
   parameter int OUT_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wb_valid,
   input  logic                          reg_we,
   input  logic [REG_AW-1:0]             rd_addr,
   input  logic [SEL_W-1:0]              sel,
   input  logic [NUM_SRC*DATA_W-1:0]     src_data,
   input  logic                          outport_enable,
   output logic                          rf_we,
   output logic [REG_AW-1:0]             rf_waddr,
   output logic [DATA_W-1:0]             rf_wdata,
   output logic                          stall,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic [cnt_w(OUT_DEPTH)-1:0]   out_count,
   output logic                          sel_err
);
   logic [DATA_W-1:0] srcs [2**SEL_W];
   logic legal, push_req, full, empty;
   for (genvar i = 0; i < 2**SEL_W; i++) begin : g_src
      if (i < NUM_SRC) begin : g_on
         assign srcs[i] = src_data[i*DATA_W +: DATA_W];
      end else begin : g_off
         assign srcs[i] = '0;
      end
   end
   assign legal     = int'(sel) < NUM_SRC;
   assign rf_wdata  = srcs[sel];
   assign rf_waddr  = rd_addr;
   assign push_req  = wb_valid & outport_enable & legal;
   assign stall     = push_req & full;
   assign rf_we     = wb_valid & reg_we & legal & ~stall;
   assign out_valid = ~empty;
   outport_fifo #(.DATA_W(DATA_W), .DEPTH(OUT_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req & ~full),
      .pop   (out_valid & out_ready),
      .wdata (rf_wdata),
      .full  (full),
      .empty (empty),
      .count (out_count),
      .rdata (out_data)
   );
`ifdef WB_SEL_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst) sel_err <= 1'b0;
      else if (wb_valid & ~legal) sel_err <= 1'b1;
   end
`else
   assign sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_outport_unit.sv
// tb_wb_outport_unit: queue-based reference model with per-cycle compare plus directed literal checks
module tb_wb_outport_unit;
   localparam int DATA_W = 16, NUM_SRC = 3, SEL_W = 2, REG_AW = 3, OUT_DEPTH = 4;
   logic clk = 0, rst = 0, wb_valid = 0, reg_we = 0, outport_enable = 0, out_ready = 0;
   logic [REG_AW-1:0] rd_addr = '0;
   logic [SEL_W-1:0] sel = '0;
   logic [NUM_SRC*DATA_W-1:0] src_data = '0;
   logic rf_we, stall, out_valid, sel_err;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata, out_data;
   logic [2:0] out_count;
   int checks = 0, errors = 0;
   bit started = 0, m_err = 0, lg, p_push, p_pop, e_stall;
   logic [DATA_W-1:0] q[$];
   wb_outport_unit #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .REG_AW(REG_AW), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .reg_we(reg_we), .rd_addr(rd_addr), .sel(sel),
      .src_data(src_data), .outport_enable(outport_enable), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_count(out_count), .sel_err(sel_err)
   );
   always #5 clk = ~clk;
   function automatic logic [DATA_W-1:0] pick();
      return int'(sel) < NUM_SRC ? DATA_W'(src_data >> (int'(sel) * DATA_W)) : '0;
   endfunction
   function automatic bit exp_err();
`ifdef WB_SEL_CHECK_EN
      return m_err;
`else
      return 1'b0;
`endif
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // model: FIFO contents as a queue, updated from the inputs seen at each edge
   always @(posedge clk) begin
      if (!rst) begin
         q.delete();
         m_err = 0;
      end else begin
         lg = int'(sel) < NUM_SRC;
         p_push = wb_valid && outport_enable && lg && q.size() < OUT_DEPTH;
         p_pop = q.size() > 0 && out_ready;
         if (p_pop) void'(q.pop_front());
         if (p_push) q.push_back(pick());
         if (wb_valid && !lg) m_err = 1;
      end
      started = 1;
   end
   always @(negedge clk) begin
      if (started) begin
         lg = int'(sel) < NUM_SRC;
         e_stall = wb_valid && outport_enable && lg && q.size() == OUT_DEPTH;
         chk("rf_wdata", 32'(rf_wdata), 32'(pick()));
         chk("rf_waddr", 32'(rf_waddr), 32'(rd_addr));
         chk("rf_we", 32'(rf_we), 32'(wb_valid && reg_we && lg && !e_stall));
         chk("stall", 32'(stall), 32'(e_stall));
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("out_data", 32'(out_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
         chk("out_count", 32'(out_count), 32'(q.size()));
         chk("sel_err", 32'(sel_err), 32'(exp_err()));
      end
   end
   initial begin
      logic [DATA_W-1:0] exp_seq [4];
      cyc();
      cyc();
      rst = 1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_count", 32'(out_count), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_sel_err", 32'(sel_err), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      src_data = {16'h0033, 16'h0022, 16'h0011};
      wb_valid = 1;
      reg_we = 1;
      rd_addr = 5;
      for (int s = 0; s < 3; s++) begin
         sel = SEL_W'(s);
         #1;
         chk("mux_data", 32'(rf_wdata), 32'h11 * (s + 1));
         chk("mux_we", 32'(rf_we), 32'h1);
         chk("mux_addr", 32'(rf_waddr), 32'h5);
      end
      cyc();
      sel = 0;
      outport_enable = 1;
      for (int i = 0; i < 4; i++) begin
         src_data[15:0] = 16'hA1 + 16'(i);
         cyc();
      end
      chk("full_count", 32'(out_count), 32'h4);
      src_data[15:0] = 16'hA5;
      #1;
      chk("full_stall", 32'(stall), 32'h1);
      chk("full_rf_we", 32'(rf_we), 32'h0);
      out_ready = 1;
      cyc();
      out_ready = 0;
      #1;
      chk("after_pop_stall", 32'(stall), 32'h0);
      chk("after_pop_head", 32'(out_data), 32'hA2);
      cyc();
      chk("a5_count", 32'(out_count), 32'h4);
      wb_valid = 0;
      outport_enable = 0;
      out_ready = 1;
      exp_seq = '{16'hA2, 16'hA3, 16'hA4, 16'hA5};
      for (int i = 0; i < 4; i++) begin
         chk("drain_a", 32'(out_data), 32'(exp_seq[i]));
         cyc();
      end
      chk("drained", 32'(out_count), 32'h0);
      out_ready = 0;
      wb_valid = 1;
      outport_enable = 1;
      src_data[15:0] = 16'hB1;
      cyc();
      src_data[15:0] = 16'hB2;
      cyc();
      src_data[15:0] = 16'hB3;
      out_ready = 1;
      cyc();
      chk("pp_count", 32'(out_count), 32'h2);
      chk("pp_head", 32'(out_data), 32'hB2);
      wb_valid = 0;
      cyc();
      chk("pp_last", 32'(out_data), 32'hB3);
      cyc();
      wb_valid = 1;
      out_ready = 0;
      src_data[15:0] = 16'hC0;
      cyc();
      out_ready = 1;
      for (int i = 1; i <= 10; i++) begin
         src_data[15:0] = 16'hC0 + 16'(i);
         #1;
         chk("wrap_head", 32'(out_data), 32'hC0 + i - 1);
         cyc();
      end
      wb_valid = 0;
      cyc();
      chk("wrap_empty", 32'(out_count), 32'h0);
      out_ready = 0;
      wb_valid = 1;
      sel = 3;
      #1;
      chk("bad_rf_we", 32'(rf_we), 32'h0);
      chk("bad_rf_wdata", 32'(rf_wdata), 32'h0);
      cyc();
      chk("bad_no_push", 32'(out_count), 32'h0);
`ifdef WB_SEL_CHECK_EN
      chk("bad_sel_err", 32'(sel_err), 32'h1);
`else
      chk("bad_sel_err", 32'(sel_err), 32'h0);
`endif
      sel = 0;
      repeat (3) cyc();
      chk("pre_rst_count", 32'(out_count), 32'h3);
      wb_valid = 0;
      rst = 0;
      cyc();
      rst = 1;
      chk("mid_rst_count", 32'(out_count), 32'h0);
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      for (int i = 0; i < 3000; i++) begin
         rst = $urandom_range(0, 199) != 0;
         wb_valid = $urandom_range(0, 3) != 0;
         reg_we = 1'($urandom);
         outport_enable = $urandom_range(0, 2) != 0;
         out_ready = $urandom_range(0, 2) == 0;
         sel = $urandom_range(0, 9) == 0 ? 2'd3 : SEL_W'($urandom_range(0, 2));
         src_data = {16'($urandom), 32'($urandom)};
         rd_addr = 3'($urandom);
         cyc();
      end
      rst = 1;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
